// File: rtl/alarm_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : alarm_timekeeper
// Purpose  : 1 Hz time-of-day counter, settable alarm and ring/snooze FSM
//            feeding hh/mm to the 7-segment display stage.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_timekeeper #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic       inc_hr,
    input  logic       inc_min,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       stop,
    output logic [5:0] Bit1,
    output logic [5:0] Bit0,
    output logic [5:0] sec_out,
    output logic       sec_tick,
    output logic       alarm_on
);

    localparam int              PW            = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   c_presc_max   = PW'(TICK_DIV - 1);
    localparam logic [11:0]     c_snooze_load = 12'(SNOOZE_MIN * 60);
    localparam logic [7:0]      c_ring_last   = 8'(RING_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [5:0]    al_hh_q, al_hh_d, al_mm_q, al_mm_d;
    logic [7:0]    ring_q, ring_d;
    logic [11:0]   snz_q, snz_d;
    logic [5:0]    bit1_q, bit1_d, bit0_q, bit0_d;
    logic          tick_q, tick_d, alarm_on_q, alarm_on_d;

    logic w_alarm_mode, w_run, w_tick, w_match;

    assign w_alarm_mode = !set_time && set_alarm;
    assign w_run        = !set_time && !set_alarm;
    // Time keeps running while the alarm is being edited; only time-set freezes it.
    assign w_tick       = !set_time && (presc_q == c_presc_max);

    always_comb begin
        presc_d = presc_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        al_hh_d = al_hh_q;
        al_mm_d = al_mm_q;

        if (set_time || w_tick) presc_d = '0;
        else                    presc_d = presc_q + PW'(1);

        if (set_time) begin
            ss_d = 6'd0;
            if (inc_hr)  hh_d = (hh_q == 6'd23) ? 6'd0 : hh_q + 6'd1;
            if (inc_min) mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
        end else if (w_tick) begin
            if (ss_q == 6'd59) begin
                ss_d = 6'd0;
                if (mm_q == 6'd59) begin
                    mm_d = 6'd0;
                    hh_d = (hh_q == 6'd23) ? 6'd0 : hh_q + 6'd1;
                end else begin
                    mm_d = mm_q + 6'd1;
                end
            end else begin
                ss_d = ss_q + 6'd1;
            end
        end

        if (w_alarm_mode) begin
            if (inc_hr)  al_hh_d = (al_hh_q == 6'd23) ? 6'd0 : al_hh_q + 6'd1;
            if (inc_min) al_mm_d = (al_mm_q == 6'd59) ? 6'd0 : al_mm_q + 6'd1;
        end
    end

    // Match is judged on the post-tick time so ringing starts on the :00 second itself.
    assign w_match = w_tick && (ss_d == 6'd0) && (hh_d == al_hh_q) && (mm_d == al_mm_q);

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        if (!alarm_en || !w_run) begin
            state_d = S_IDLE;
            ring_d  = 8'd0;
            snz_d   = 12'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_match) begin
                        state_d = S_RINGING;
                        ring_d  = 8'd0;
                    end
                end
                S_RINGING: begin
                    if (stop) begin
                        state_d = S_IDLE;
                        ring_d  = 8'd0;
                    end else if (snooze) begin
                        state_d = S_SNOOZE;
                        snz_d   = c_snooze_load;
                        ring_d  = 8'd0;
                    end else if (w_tick) begin
                        if (ring_q == c_ring_last) begin
                            state_d = S_IDLE;
                            ring_d  = 8'd0;
                        end else begin
                            ring_d = ring_q + 8'd1;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (stop) begin
                        state_d = S_IDLE;
                        snz_d   = 12'd0;
                    end else if (w_tick) begin
                        if (snz_q == 12'd1) begin
                            state_d = S_RINGING;
                            ring_d  = 8'd0;
                            snz_d   = 12'd0;
                        end else begin
                            snz_d = snz_q - 12'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    ring_d  = 8'd0;
                    snz_d   = 12'd0;
                end
            endcase
        end

        alarm_on_d = (state_d == S_RINGING);
        tick_d     = w_tick;
        bit1_d     = w_alarm_mode ? al_hh_q : hh_q;
        bit0_d     = w_alarm_mode ? al_mm_q : mm_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            hh_q       <= 6'd0;
            mm_q       <= 6'd0;
            ss_q       <= 6'd0;
            al_hh_q    <= 6'd7;
            al_mm_q    <= 6'd0;
            ring_q     <= 8'd0;
            snz_q      <= 12'd0;
            bit1_q     <= 6'd0;
            bit0_q     <= 6'd0;
            tick_q     <= 1'b0;
            alarm_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            al_hh_q    <= al_hh_d;
            al_mm_q    <= al_mm_d;
            ring_q     <= ring_d;
            snz_q      <= snz_d;
            bit1_q     <= bit1_d;
            bit0_q     <= bit0_d;
            tick_q     <= tick_d;
            alarm_on_q <= alarm_on_d;
        end
    end

    assign Bit1     = bit1_q;
    assign Bit0     = bit0_q;
    assign sec_out  = ss_q;
    assign sec_tick = tick_q;
    assign alarm_on = alarm_on_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_timekeeper
// Purpose  : Directed and random stimulus against a seconds-of-day reference
//            model, compared on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_timekeeper;

    localparam int TD = 4;
    localparam int SM = 1;
    localparam int RS = 10;

    logic       CLK = 1'b0, RST = 1'b0;
    logic       set_time = 1'b0, set_alarm = 1'b0, inc_hr = 1'b0, inc_min = 1'b0;
    logic       alarm_en = 1'b0, snooze = 1'b0, stop = 1'b0;
    logic [5:0] Bit1, Bit0, sec_out;
    logic       sec_tick, alarm_on;

    alarm_timekeeper #(.TICK_DIV(TD), .SNOOZE_MIN(SM), .RING_SEC(RS)) dut (
        .CLK(CLK), .RST(RST), .set_time(set_time), .set_alarm(set_alarm),
        .inc_hr(inc_hr), .inc_min(inc_min), .alarm_en(alarm_en),
        .snooze(snooze), .stop(stop), .Bit1(Bit1), .Bit0(Bit0),
        .sec_out(sec_out), .sec_tick(sec_tick), .alarm_on(alarm_on)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: time as seconds of day, alarm as minutes of day.
    // m_state: 0 quiet, 1 ringing, 2 snoozing.
    int   m_tod = 0, m_alarm = 420, m_cyc = 0, m_state = 0;
    int   m_ring_left = 0, m_snz_left = 0, md = 0, h = 0, m = 0;
    bit   tk = 1'b0;
    logic [5:0] e_b1 = '0, e_b0 = '0, e_sec = '0;
    logic       e_tick = 1'b0, e_on = 1'b0;

    initial forever begin
        @(posedge CLK or posedge RST);
        if (RST) begin
            m_tod = 0; m_alarm = 420; m_cyc = 0; m_state = 0;
            e_b1 = '0; e_b0 = '0; e_sec = '0; e_tick = 1'b0; e_on = 1'b0;
        end else begin
            md   = set_time ? 1 : (set_alarm ? 2 : 0);
            e_b1 = (md == 2) ? 6'(m_alarm / 60) : 6'(m_tod / 3600);
            e_b0 = (md == 2) ? 6'(m_alarm % 60) : 6'((m_tod / 60) % 60);
            tk   = 1'b0;
            if (md == 1) m_cyc = 0;
            else begin
                m_cyc++;
                if (m_cyc == TD) begin m_cyc = 0; tk = 1'b1; end
            end
            if (md == 1) begin
                h = m_tod / 3600; m = (m_tod / 60) % 60;
                if (inc_hr)  h = (h + 1) % 24;
                if (inc_min) m = (m + 1) % 60;
                m_tod = h * 3600 + m * 60;
            end else if (tk) begin
                m_tod = (m_tod + 1) % 86400;
            end
            if (md == 2) begin
                h = m_alarm / 60; m = m_alarm % 60;
                if (inc_hr)  h = (h + 1) % 24;
                if (inc_min) m = (m + 1) % 60;
                m_alarm = h * 60 + m;
            end
            if (!alarm_en || md != 0) m_state = 0;
            else if (m_state == 0) begin
                if (tk && m_tod % 60 == 0 && m_tod / 60 == m_alarm) begin
                    m_state = 1; m_ring_left = RS;
                end
            end else if (m_state == 1) begin
                if (stop) m_state = 0;
                else if (snooze) begin m_state = 2; m_snz_left = SM * 60; end
                else if (tk) begin
                    m_ring_left--;
                    if (m_ring_left == 0) m_state = 0;
                end
            end else begin
                if (stop) m_state = 0;
                else if (tk) begin
                    m_snz_left--;
                    if (m_snz_left == 0) begin m_state = 1; m_ring_left = RS; end
                end
            end
            e_sec  = 6'(m_tod % 60);
            e_tick = tk;
            e_on   = (m_state == 1);
        end
    end

    initial forever begin
        @(negedge CLK);
        if (!RST) begin
            check("model_bit1", int'(Bit1), int'(e_b1));
            check("model_bit0", int'(Bit0), int'(e_b0));
            check("model_sec", int'(sec_out), int'(e_sec));
            check("model_tick", int'(sec_tick), int'(e_tick));
            check("model_alarm_on", int'(alarm_on), int'(e_on));
        end
    end

    task automatic pulse_inc(input logic hr, input logic mn);
        @(negedge CLK); inc_hr = hr; inc_min = mn;
        @(negedge CLK); inc_hr = 1'b0; inc_min = 1'b0;
    endtask

    task automatic posedges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Freeze time at one minute before the alarm; the alarm fires 60 ticks after return.
    task automatic arm_ring();
        int cur_h, cur_m, tgt, kh, km;
        @(negedge CLK);
        inc_hr = 1'b0; inc_min = 1'b0; snooze = 1'b0; stop = 1'b0;
        set_alarm = 1'b0; set_time = 1'b1;
        @(negedge CLK);
        cur_h = m_tod / 3600; cur_m = (m_tod / 60) % 60;
        tgt   = (m_alarm + 1439) % 1440;
        kh    = (tgt / 60 - cur_h + 24) % 24;
        km    = (tgt % 60 - cur_m + 60) % 60;
        for (int i = 0; i < kh; i++) pulse_inc(1'b1, 1'b0);
        for (int i = 0; i < km; i++) pulse_inc(1'b0, 1'b1);
        @(negedge CLK); set_time = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_bit1"}, int'(Bit1), 0);
        check({tag, "_bit0"}, int'(Bit0), 0);
        check({tag, "_sec"}, int'(sec_out), 0);
        check({tag, "_tick"}, int'(sec_tick), 0);
        check({tag, "_alarm_on"}, int'(alarm_on), 0);
    endtask

    initial begin
        int cnt;
        bit found;

        // Reset, mid-count reset, first tick latency, alarm default 07:00
        #1 RST = 1'b1;
        #1 check_zero_outputs("por");
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        posedges(5);
        @(posedge CLK); #2 RST = 1'b1;
        #1 check_zero_outputs("async_rst");
        @(negedge CLK); RST = 1'b0;
        cnt = 0; found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            posedges(1); cnt++;
            if (sec_tick) found = 1'b1;
        end
        check("first_tick_found", int'(found), 1);
        check("first_tick_cycles", cnt, 4);
        @(negedge CLK); set_alarm = 1'b1;
        posedges(1);
        check("alarm_default_hh", int'(Bit1), 7);
        check("alarm_default_mm", int'(Bit0), 0);
        @(negedge CLK); set_alarm = 1'b0;

        // Set 23:59, run 60 ticks through midnight
        @(negedge CLK); set_time = 1'b1;
        for (int i = 0; i < 59; i++) pulse_inc(i < 23, 1'b1);
        @(negedge CLK); set_time = 1'b0;
        posedges(1);
        check("set_23_hh", int'(Bit1), 23);
        check("set_23_mm", int'(Bit0), 59);
        posedges(240);
        check("wrap_hh", int'(Bit1), 0);
        check("wrap_mm", int'(Bit0), 0);
        check("wrap_sec", int'(sec_out), 0);

        // Alarm edit to 09:00 while time keeps ticking, then to 00:01
        @(negedge CLK); set_alarm = 1'b1;
        pulse_inc(1'b1, 1'b0);
        pulse_inc(1'b1, 1'b0);
        posedges(1);
        check("alarm_09_hh", int'(Bit1), 9);
        check("alarm_09_mm", int'(Bit0), 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            posedges(1);
            if (sec_tick) cnt++;
        end
        check("ticks_during_alarm_edit", cnt, 2);
        for (int i = 0; i < 15; i++) pulse_inc(1'b1, 1'b0);
        pulse_inc(1'b0, 1'b1);
        @(negedge CLK); set_alarm = 1'b0;

        // Ring at 00:01:00, auto-timeout after RING_SEC ticks
        alarm_en = 1'b1;
        arm_ring();
        posedges(239);
        check("ring_before", int'(alarm_on), 0);
        posedges(1);
        check("ring_rise", int'(alarm_on), 1);
        check("ring_rise_tick", int'(sec_tick), 1);
        posedges(39);
        check("ring_hold", int'(alarm_on), 1);
        posedges(1);
        check("ring_timeout", int'(alarm_on), 0);

        // Snooze for one minute, then stop+snooze together
        arm_ring();
        posedges(240);
        check("snz_ring", int'(alarm_on), 1);
        @(negedge CLK); snooze = 1'b1;
        @(negedge CLK); snooze = 1'b0;
        check("snz_quiet", int'(alarm_on), 0);
        posedges(238);
        check("snz_before", int'(alarm_on), 0);
        posedges(1);
        check("snz_rering", int'(alarm_on), 1);
        @(negedge CLK); stop = 1'b1; snooze = 1'b1;
        @(negedge CLK); stop = 1'b0; snooze = 1'b0;
        check("stop_wins", int'(alarm_on), 0);
        posedges(240);
        check("stop_no_rering", int'(alarm_on), 0);

        // Leaving RUN or disarming silences the alarm at once
        arm_ring();
        posedges(240);
        check("kill_ts_ring", int'(alarm_on), 1);
        @(negedge CLK); set_time = 1'b1;
        posedges(1);
        check("kill_set_time", int'(alarm_on), 0);
        @(negedge CLK); set_time = 1'b0;
        posedges(100);
        check("kill_ts_stays", int'(alarm_on), 0);
        arm_ring();
        posedges(240);
        check("kill_en_ring", int'(alarm_on), 1);
        @(negedge CLK); alarm_en = 1'b0;
        posedges(1);
        check("kill_alarm_en", int'(alarm_on), 0);
        @(negedge CLK); alarm_en = 1'b1;
        posedges(100);
        check("kill_en_stays", int'(alarm_on), 0);

        // Random traffic with periodic arming
        for (int c = 0; c < 3000; c++) begin
            if (c % 600 == 0) begin
                alarm_en = 1'b1;
                arm_ring();
            end
            @(negedge CLK);
            inc_hr  = ($urandom % 8 == 0);
            inc_min = ($urandom % 8 == 0);
            snooze  = ($urandom % 40 == 0);
            stop    = ($urandom % 60 == 0);
            if (set_time)  set_time  = ($urandom % 4 != 0);
            else           set_time  = ($urandom % 400 == 0);
            if (set_alarm) set_alarm = ($urandom % 4 != 0);
            else           set_alarm = ($urandom % 300 == 0);
            if ($urandom % 250 == 0) alarm_en = ~alarm_en;
        end
        @(negedge CLK);
        inc_hr = 1'b0; inc_min = 1'b0; snooze = 1'b0; stop = 1'b0;
        set_time = 1'b0; set_alarm = 1'b0;
        posedges(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
